id_stage: RTL and testbench

Instruction-decode stage of the five-stage pipeline, directly downstream of instruction fetch. Consumes the 64-bit `IF_ID` register `{PC_plus4, instruction}`, holds the 32×32 register file, and resolves branches, jumps and `jr`/`jalr` in ID. Detects load-use and branch-operand hazards, and raises interrupt/exception status. Drives the fetch-control signals back to IF and produces the `ID_EX` pipeline register.

---
 rtl/id_if.sv | 34 +++
 rtl/id_stage.sv | 173 +++++++++++++++++
 tb/tb_id_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_if.sv
// Decode-stage bus: IF_ID/write-back/EX_MEM inputs and the fetch-control/ID_EX outputs.
// master drives the stage inputs; slave is the id_stage side.
interface id_if;
  logic [63:0]  IF_ID;
  logic         irq;
  logic         wb_RegWrite;
  logic [4:0]   wb_dst;
  logic [31:0]  wb_data;
  logic         EX_MEM_RegWrite;
  logic         EX_MEM_MemRead;
  logic [4:0]   EX_MEM_dst;
  logic [31:0]  EX_MEM_data;
  logic [31:0]  branch_target;
  logic [31:0]  jump_target;
  logic [31:0]  jr_target;
  logic [2:0]   select_PC_next;
  logic [1:0]   status;
  logic         PC_IF_ID_Write;
  logic [165:0] ID_EX;

  modport master (
    output IF_ID, irq, wb_RegWrite, wb_dst, wb_data,
           EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_dst, EX_MEM_data,
    input  branch_target, jump_target, jr_target, select_PC_next,
           status, PC_IF_ID_Write, ID_EX
  );

  modport slave (
    input  IF_ID, irq, wb_RegWrite, wb_dst, wb_data,
           EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_dst, EX_MEM_data,
    output branch_target, jump_target, jr_target, select_PC_next,
           status, PC_IF_ID_Write, ID_EX
  );
endinterface

// File: rtl/id_stage.sv
// Instruction decode: register file, branch/jump resolution, hazard stall, irq/exception status.
// Latency: fetch-control outputs combinational; ID_EX registered, 1 cycle. Backpressure: none downstream;
// stalls IF via PC_IF_ID_Write=0 and injects a bubble. ID_BRANCH_FWD_EN enables EX_MEM branch forwarding.
module id_stage #(
  parameter logic [4:0] XREG = 5'd26
) (
  input logic clk,
  input logic rst_n,
  id_if.slave bus
);
  typedef struct packed {
    logic reg_write, mem_read, mem_write, mem_to_reg, alu_src, link;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc_plus4, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, dst, shamt;
    logic [5:0]  op, funct;
    ctrl_t       ctrl;
  } id_ex_t;

  logic [31:0] instr, pc_plus4;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign pc_plus4 = bus.IF_ID[63:32];
  assign instr    = bus.IF_ID[31:0];
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];

  logic is_r_alu, is_shift, is_jr, is_jalr, is_i_arith, is_i_logic, is_lui;
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal;

  always_comb begin
    {is_r_alu, is_shift, is_jr, is_jalr, is_i_arith, is_i_logic, is_lui} = '0;
    {is_lw, is_sw, is_beq, is_bne, is_j, is_jal} = '0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B: is_r_alu = 1'b1;
          6'h00, 6'h02, 6'h03:        is_shift = 1'b1;
          6'h08:                      is_jr    = 1'b1;
          6'h09:                      is_jalr  = 1'b1;
          default: ;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: is_i_arith = 1'b1;
      6'h0C, 6'h0D, 6'h0E:        is_i_logic = 1'b1;
      6'h0F:                      is_lui     = 1'b1;
      6'h23:                      is_lw      = 1'b1;
      6'h2B:                      is_sw      = 1'b1;
      6'h04:                      is_beq     = 1'b1;
      6'h05:                      is_bne     = 1'b1;
      6'h02:                      is_j       = 1'b1;
      6'h03:                      is_jal     = 1'b1;
      default: ;
    endcase
  end

  logic defined, nonzero, valid, uses_rs, uses_rt, is_branch;
  assign defined   = is_r_alu | is_shift | is_jr | is_jalr | is_i_arith | is_i_logic | is_lui |
                     is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
  assign nonzero   = |instr;
  assign valid     = defined & nonzero;
  assign uses_rs   = valid & (is_r_alu | is_jr | is_jalr | is_i_arith | is_i_logic |
                              is_lw | is_sw | is_beq | is_bne);
  assign uses_rt   = valid & (is_r_alu | is_shift | is_sw | is_beq | is_bne);
  assign is_branch = is_beq | is_bne | is_jr | is_jalr;

  logic [31:0] rf [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wb_RegWrite && bus.wb_dst != 5'd0) begin
      rf[bus.wb_dst] <= bus.wb_data;
    end
  end

  // Write-through so a value retiring this cycle is visible to the reader in ID.
  logic [31:0] rs_val, rt_val;
  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (bus.wb_RegWrite && bus.wb_dst == rs) ? bus.wb_data : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (bus.wb_RegWrite && bus.wb_dst == rt) ? bus.wb_data : rf[rt];

  id_ex_t id_ex_q, id_ex_d;

  logic idex_hit_rs, idex_hit_rt, load_use, ex_hit_rs, ex_hit_rt, ex_stall, stall;
  assign idex_hit_rs = uses_rs && id_ex_q.dst != 5'd0 && id_ex_q.dst == rs;
  assign idex_hit_rt = uses_rt && id_ex_q.dst != 5'd0 && id_ex_q.dst == rt;
  assign load_use    = id_ex_q.ctrl.mem_read && (idex_hit_rs || idex_hit_rt);
  assign ex_hit_rs   = uses_rs && bus.EX_MEM_RegWrite && bus.EX_MEM_dst != 5'd0 &&
                       bus.EX_MEM_dst == rs;
  assign ex_hit_rt   = uses_rt && bus.EX_MEM_RegWrite && bus.EX_MEM_dst != 5'd0 &&
                       bus.EX_MEM_dst == rt;

  logic [31:0] op_a, op_b;
`ifdef ID_BRANCH_FWD_EN
  assign ex_stall = is_branch && (ex_hit_rs || ex_hit_rt) && bus.EX_MEM_MemRead;
  assign op_a     = (ex_hit_rs && !bus.EX_MEM_MemRead) ? bus.EX_MEM_data : rs_val;
  assign op_b     = (ex_hit_rt && !bus.EX_MEM_MemRead) ? bus.EX_MEM_data : rt_val;
`else
  logic unused_fwd;
  assign unused_fwd = &{1'b0, bus.EX_MEM_MemRead, bus.EX_MEM_data};
  assign ex_stall   = is_branch && (ex_hit_rs || ex_hit_rt);
  assign op_a       = rs_val;
  assign op_b       = rt_val;
`endif

  assign stall = load_use || ex_stall ||
                 (is_branch && id_ex_q.ctrl.reg_write && (idex_hit_rs || idex_hit_rt));

  logic irq_take, exc, take, z;
  assign irq_take = bus.irq && !pc_plus4[31] && nonzero && !stall;
  assign exc      = !defined && nonzero;
  assign take     = valid && !stall && !irq_take;
  assign z        = (is_beq && op_a == op_b) || (is_bne && op_a != op_b);

  logic [31:0] br_sum;
  assign br_sum = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

  assign bus.branch_target  = {pc_plus4[31], br_sum[30:0]};
  assign bus.jump_target    = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign bus.jr_target      = op_a;
  assign bus.select_PC_next = take ? {z, is_j | is_jal, is_jr | is_jalr} : 3'b000;
  assign bus.status         = {irq_take, exc && !irq_take};
  assign bus.PC_IF_ID_Write = !stall;

  always_comb begin
    id_ex_d = '0;
    if (irq_take || exc) begin
      // Interrupt returns to this instruction; exception returns past it.
      id_ex_d.pc_plus4       = irq_take ? pc_plus4 - 32'd4 : pc_plus4;
      id_ex_d.dst            = XREG;
      id_ex_d.ctrl.reg_write = 1'b1;
      id_ex_d.ctrl.link      = 1'b1;
    end else if (take) begin
      id_ex_d.pc_plus4 = pc_plus4;
      id_ex_d.rs_data  = rs_val;
      id_ex_d.rt_data  = rt_val;
      id_ex_d.imm      = is_i_logic ? {16'h0, imm16} :
                         is_lui     ? {imm16, 16'h0} : {{16{imm16[15]}}, imm16};
      id_ex_d.rs       = rs;
      id_ex_d.rt       = rt;
      id_ex_d.dst      = is_jal ? 5'd31 : (op == 6'h00) ? rd : rt;
      id_ex_d.shamt    = shamt;
      id_ex_d.op       = op;
      id_ex_d.funct    = funct;
      id_ex_d.ctrl.reg_write  = is_r_alu | is_shift | is_jalr | is_i_arith | is_i_logic |
                                is_lui | is_lw | is_jal;
      id_ex_d.ctrl.mem_read   = is_lw;
      id_ex_d.ctrl.mem_write  = is_sw;
      id_ex_d.ctrl.mem_to_reg = is_lw;
      id_ex_d.ctrl.alu_src    = is_i_arith | is_i_logic | is_lui | is_lw | is_sw;
      id_ex_d.ctrl.link       = is_jal | is_jalr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) id_ex_q <= '0;
    else        id_ex_q <= id_ex_d;
  end

  assign bus.ID_EX = id_ex_q;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: vector table for single-instruction decode plus hazard/reset sequences.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  id_if bus ();

  id_stage #(.XREG(5'd26)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  logic [165:0] exp_q [$];

  typedef struct {
    string        nm;
    logic [63:0]  ifid;
    logic         irq;
    logic [2:0]   sel;
    logic [1:0]   st;
    logic         wr;
    int           tsel;
    logic [31:0]  tgt;
    logic [165:0] idex;
  } vec_t;
  vec_t vecs [$];

  function automatic logic [165:0] mk(input logic [31:0] pc4, rsd, rtd, imm,
                                      input logic [4:0] rs, rt, dst, sh,
                                      input logic [5:0] op, fn, ctrl);
    return {pc4, rsd, rtd, imm, rs, rt, dst, sh, op, fn, ctrl};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rs, rt,
                                     input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic chk(input string nm, input logic [165:0] act, input logic [165:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] ifid, input logic irq);
    bus.IF_ID = ifid;
    bus.irq   = irq;
  endtask

  task automatic wbw(input logic en, input logic [4:0] dst, input logic [31:0] dat);
    bus.wb_RegWrite = en;
    bus.wb_dst      = dst;
    bus.wb_data     = dat;
  endtask

  task automatic exm(input logic rw, input logic mr, input logic [4:0] dst, input logic [31:0] dat);
    bus.EX_MEM_RegWrite = rw;
    bus.EX_MEM_MemRead  = mr;
    bus.EX_MEM_dst      = dst;
    bus.EX_MEM_data     = dat;
  endtask

  // Check combinational outputs mid-cycle, then the ID_EX value captured at the next edge.
  task automatic cycle(input string nm, input logic [2:0] esel, input logic [1:0] est,
                       input logic ewr, input int tsel, input logic [31:0] etgt,
                       input logic [165:0] eidex);
    #1;
    chk({nm, ".sel"},    166'(bus.select_PC_next), 166'(esel));
    chk({nm, ".status"}, 166'(bus.status),         166'(est));
    chk({nm, ".pcwr"},   166'(bus.PC_IF_ID_Write), 166'(ewr));
    if (tsel == 1) chk({nm, ".btgt"}, 166'(bus.branch_target), 166'(etgt));
    if (tsel == 2) chk({nm, ".jtgt"}, 166'(bus.jump_target),   166'(etgt));
    if (tsel == 3) chk({nm, ".jrtgt"}, 166'(bus.jr_target),    166'(etgt));
    exp_q.push_back(eidex);
    @(posedge clk);
    #1;
    chk({nm, ".id_ex"}, bus.ID_EX, exp_q.pop_front());
  endtask

  task automatic add_vec(input string nm, input logic [31:0] pc4, input logic [31:0] ins,
                         input logic irq, input logic [2:0] sel, input logic [1:0] st,
                         input logic wr, input int tsel, input logic [31:0] tgt,
                         input logic [165:0] idex);
    vec_t v;
    v.nm = nm; v.ifid = {pc4, ins}; v.irq = irq; v.sel = sel; v.st = st;
    v.wr = wr; v.tsel = tsel; v.tgt = tgt; v.idex = idex;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] add10, undef;
    add10 = rr(5'd1, 5'd2, 5'd10, 5'd0, 6'h20);
    undef = 32'hFC000000;
    drive('0, 1'b0);
    wbw(1'b0, 5'd0, 32'd0);
    exm(1'b0, 1'b0, 5'd0, 32'd0);

    #12;
    chk("reset.id_ex",  bus.ID_EX, '0);
    chk("reset.sel",    166'(bus.select_PC_next), 166'(3'b000));
    chk("reset.status", 166'(bus.status), 166'(2'b00));
    chk("reset.pcwr",   166'(bus.PC_IF_ID_Write), 166'(1'b1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    wbw(1'b1, 5'd1, 32'd5);     cycle("wr1", 3'b000, 2'b00, 1'b1, 0, 0, '0);
    wbw(1'b1, 5'd2, 32'd5);     cycle("wr2", 3'b000, 2'b00, 1'b1, 0, 0, '0);
    wbw(1'b1, 5'd9, 32'h100);   cycle("wr9", 3'b000, 2'b00, 1'b1, 0, 0, '0);

    // Write-through and $0 hardwiring.
    wbw(1'b1, 5'd5, 32'h55);
    drive({32'h30, rr(5'd5, 5'd0, 5'd6, 5'd0, 6'h20)}, 1'b0);
    cycle("wthru", 3'b000, 2'b00, 1'b1, 0, 0,
          mk(32'h30, 32'h55, 0, 32'h3020, 5, 0, 6, 0, 6'h00, 6'h20, 6'h20));
    wbw(1'b1, 5'd0, 32'hDEAD);
    drive({32'h34, rr(5'd0, 5'd5, 5'd6, 5'd0, 6'h20)}, 1'b0);
    cycle("r0zero", 3'b000, 2'b00, 1'b1, 0, 0,
          mk(32'h34, 0, 32'h55, 32'h3020, 0, 5, 6, 0, 6'h00, 6'h20, 6'h20));
    wbw(1'b0, 5'd0, 32'd0);

    add_vec("beq_taken", 32'h10, ri(6'h04, 1, 2, 16'd3), 1'b0, 3'b100, 2'b00, 1'b1, 1, 32'h1C,
            mk(32'h10, 5, 5, 3, 1, 2, 2, 0, 6'h04, 6'h03, 6'h00));
    add_vec("bne_nt", 32'h10, ri(6'h05, 1, 2, 16'd3), 1'b0, 3'b000, 2'b00, 1'b1, 1, 32'h1C,
            mk(32'h10, 5, 5, 3, 1, 2, 2, 0, 6'h05, 6'h03, 6'h00));
    add_vec("jal", 32'h80000040, 32'h0C000100, 1'b0, 3'b010, 2'b00, 1'b1, 2, 32'h80000400,
            mk(32'h80000040, 0, 0, 32'h100, 0, 0, 31, 4, 6'h03, 6'h00, 6'h21));
    add_vec("j", 32'h100, 32'h08000010, 1'b0, 3'b010, 2'b00, 1'b1, 2, 32'h40,
            mk(32'h100, 0, 0, 32'h10, 0, 0, 0, 0, 6'h02, 6'h10, 6'h00));
    add_vec("jr", 32'h200, rr(5'd9, 5'd0, 5'd0, 5'd0, 6'h08), 1'b0, 3'b001, 2'b00, 1'b1, 3, 32'h100,
            mk(32'h200, 32'h100, 0, 8, 9, 0, 0, 0, 6'h00, 6'h08, 6'h00));
    add_vec("ori_zext", 32'h20, ri(6'h0D, 1, 4, 16'h8000), 1'b0, 3'b000, 2'b00, 1'b1, 0, 0,
            mk(32'h20, 5, 0, 32'h8000, 1, 4, 4, 0, 6'h0D, 6'h00, 6'h22));
    add_vec("addi_sext", 32'h24, ri(6'h08, 1, 4, 16'hFFFF), 1'b0, 3'b000, 2'b00, 1'b1, 0, 0,
            mk(32'h24, 5, 0, 32'hFFFFFFFF, 1, 4, 4, 5'h1F, 6'h08, 6'h3F, 6'h22));
    add_vec("lui", 32'h28, ri(6'h0F, 0, 4, 16'h1234), 1'b0, 3'b000, 2'b00, 1'b1, 0, 0,
            mk(32'h28, 0, 0, 32'h12340000, 0, 4, 4, 5'd8, 6'h0F, 6'h34, 6'h22));
    add_vec("sw", 32'h2C, ri(6'h2B, 1, 2, 16'd4), 1'b0, 3'b000, 2'b00, 1'b1, 0, 0,
            mk(32'h2C, 5, 5, 4, 1, 2, 2, 0, 6'h2B, 6'h04, 6'h0A));
    add_vec("exception", 32'h44, undef, 1'b0, 3'b000, 2'b01, 1'b1, 0, 0,
            mk(32'h44, 0, 0, 0, 0, 0, 26, 0, 6'h00, 6'h00, 6'h21));
    add_vec("interrupt", 32'h24, add10, 1'b1, 3'b000, 2'b10, 1'b1, 0, 0,
            mk(32'h20, 0, 0, 0, 0, 0, 26, 0, 6'h00, 6'h00, 6'h21));
    add_vec("irq_kernel", 32'h80000024, add10, 1'b1, 3'b000, 2'b00, 1'b1, 0, 0,
            mk(32'h80000024, 5, 5, 32'h5020, 1, 2, 10, 0, 6'h00, 6'h20, 6'h20));
    add_vec("irq_bubble", 32'h0, 32'h0, 1'b1, 3'b000, 2'b00, 1'b1, 0, 0, '0);
    add_vec("irq_over_exc", 32'h48, undef, 1'b1, 3'b000, 2'b10, 1'b1, 0, 0,
            mk(32'h44, 0, 0, 0, 0, 0, 26, 0, 6'h00, 6'h00, 6'h21));

    foreach (vecs[k]) begin
      drive(vecs[k].ifid, vecs[k].irq);
      cycle(vecs[k].nm, vecs[k].sel, vecs[k].st, vecs[k].wr, vecs[k].tsel, vecs[k].tgt, vecs[k].idex);
      drive('0, 1'b0);
      cycle({vecs[k].nm, ".gap"}, 3'b000, 2'b00, 1'b1, 0, 0, '0);
    end

    // Load-use: one stall, interrupt held off while stalled.
    drive({32'h50, ri(6'h23, 9, 8, 16'd0)}, 1'b0);
    cycle("lu.lw", 3'b000, 2'b00, 1'b1, 0, 0,
          mk(32'h50, 32'h100, 0, 0, 9, 8, 8, 0, 6'h23, 6'h00, 6'h36));
    drive({32'h54, rr(5'd8, 5'd8, 5'd10, 5'd0, 6'h20)}, 1'b1);
    cycle("lu.stall", 3'b000, 2'b00, 1'b0, 0, 0, '0);
    bus.irq = 1'b0;
    wbw(1'b1, 5'd8, 32'h77);
    cycle("lu.add", 3'b000, 2'b00, 1'b1, 0, 0,
          mk(32'h54, 32'h77, 32'h77, 32'h5020, 8, 8, 10, 0, 6'h00, 6'h20, 6'h20));
    wbw(1'b0, 5'd0, 32'd0);
    drive('0, 1'b0);
    cycle("lu.gap", 3'b000, 2'b00, 1'b1, 0, 0, '0);

    // ALU result feeding bne.
    drive({32'h60, ri(6'h08, 0, 3, 16'd7)}, 1'b0);
    cycle("alu.addi", 3'b000, 2'b00, 1'b1, 0, 0,
          mk(32'h60, 0, 0, 7, 0, 3, 3, 0, 6'h08, 6'h07, 6'h22));
    drive({32'h64, ri(6'h05, 3, 0, 16'hFFFF)}, 1'b0);
    cycle("alu.stall1", 3'b000, 2'b00, 1'b0, 0, 0, '0);
    exm(1'b1, 1'b0, 5'd3, 32'd7);
`ifdef ID_BRANCH_FWD_EN
    cycle("alu.bne_fwd", 3'b100, 2'b00, 1'b1, 1, 32'h60,
          mk(32'h64, 0, 0, 32'hFFFFFFFF, 3, 0, 0, 5'h1F, 6'h05, 6'h3F, 6'h00));
`else
    cycle("alu.stall2", 3'b000, 2'b00, 1'b0, 0, 0, '0);
    exm(1'b0, 1'b0, 5'd0, 32'd0);
    wbw(1'b1, 5'd3, 32'd7);
    cycle("alu.bne_rf", 3'b100, 2'b00, 1'b1, 1, 32'h60,
          mk(32'h64, 7, 0, 32'hFFFFFFFF, 3, 0, 0, 5'h1F, 6'h05, 6'h3F, 6'h00));
    wbw(1'b0, 5'd0, 32'd0);
`endif
    exm(1'b0, 1'b0, 5'd0, 32'd0);
    drive('0, 1'b0);
    cycle("alu.gap", 3'b000, 2'b00, 1'b1, 0, 0, '0);

    // Load feeding beq: two stalls in either build.
    drive({32'h70, ri(6'h23, 9, 11, 16'd0)}, 1'b0);
    cycle("ld.lw", 3'b000, 2'b00, 1'b1, 0, 0,
          mk(32'h70, 32'h100, 0, 0, 9, 11, 11, 0, 6'h23, 6'h00, 6'h36));
    drive({32'h74, ri(6'h04, 11, 1, 16'd1)}, 1'b0);
    cycle("ld.stall1", 3'b000, 2'b00, 1'b0, 0, 0, '0);
    exm(1'b1, 1'b1, 5'd11, 32'hBAD);
    cycle("ld.stall2", 3'b000, 2'b00, 1'b0, 0, 0, '0);
    exm(1'b0, 1'b0, 5'd0, 32'd0);
    wbw(1'b1, 5'd11, 32'd5);
    cycle("ld.beq", 3'b100, 2'b00, 1'b1, 1, 32'h78,
          mk(32'h74, 5, 5, 1, 11, 1, 1, 0, 6'h04, 6'h01, 6'h00));
    wbw(1'b0, 5'd0, 32'd0);
    drive('0, 1'b0);
    cycle("ld.gap", 3'b000, 2'b00, 1'b1, 0, 0, '0);

    // Reset in the middle of a load-use stall.
    drive({32'h80, ri(6'h23, 9, 8, 16'd0)}, 1'b0);
    cycle("rst.lw", 3'b000, 2'b00, 1'b1, 0, 0,
          mk(32'h80, 32'h100, 32'h77, 0, 9, 8, 8, 0, 6'h23, 6'h00, 6'h36));
    drive({32'h84, rr(5'd8, 5'd8, 5'd10, 5'd0, 6'h20)}, 1'b0);
    #1;
    chk("rst.pre_stall", 166'(bus.PC_IF_ID_Write), 166'(1'b0));
    rst_n = 1'b0;
    #1;
    chk("rst.id_ex_async", bus.ID_EX, '0);
    chk("rst.stall_drop", 166'(bus.PC_IF_ID_Write), 166'(1'b1));
    drive('0, 1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive({32'h90, add10}, 1'b0);
    cycle("rst.regs_zero", 3'b000, 2'b00, 1'b1, 0, 0,
          mk(32'h90, 0, 0, 32'h5020, 1, 2, 10, 0, 6'h00, 6'h20, 6'h20));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
